// File: rtl/traffic_pkg.sv
// Shared phase encodings and per-way light codes for the multi-way traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALLRED  = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2,
        PH_PREEMPT = 2'd3
    } phase_e;

    // Each way is driven {red, yellow, green}.
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle registered tick every TICK_DIV clk_in cycles, the first
// one on cycle TICK_DIV after reset release.
module tick_gen #(
    parameter int TICK_DIV = 200000
) (
    input  logic clk_in,
    input  logic rst_a_n,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // NOTE: every variable gets a value on every path, so no latch can be inferred.
    always_comb begin
        tick_d = (cnt_q == CNT_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so flops update together.
    always_ff @(posedge clk_in or negedge rst_a_n) begin
        if (!rst_a_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_way_traffic_ctrl.sv
// Round-robin traffic controller for NUM_WAYS approaches, with demand-based skipping
// and emergency preemption; all state advances only on prescaler ticks.
module multi_way_traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_WAYS     = 4,
    parameter int TICK_DIV     = 200000,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_a_n,
    input  logic                  skip_en,
    input  logic [NUM_WAYS-1:0]   demand,
    input  logic                  preempt_req,
    input  logic [2:0]            preempt_way,
    output logic [3*NUM_WAYS-1:0] lights,
    output logic [2:0]            active_way,
    output logic [1:0]            phase,
    output logic                  tick_out
);

    localparam int CNT_W = $clog2(max3(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS)) + 1;
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_TICKS - 1);

    logic tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_in  (clk_in),
        .rst_a_n (rst_a_n),
        .tick    (tick)
    );

    phase_e           phase_q, phase_d;
    logic [2:0]       active_way_q, active_way_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fresh_q, fresh_d;
    logic             pend_q, pend_d;
    logic [2:0]       pend_way_q, pend_way_d;

    logic       preempt_valid, pend_now, sel_found;
    logic [2:0] pend_way_now, sel_way;
    int         start_idx, idx;

    assign preempt_valid = preempt_req && (int'(preempt_way) < NUM_WAYS);
    assign pend_now      = pend_q || preempt_valid;
    assign pend_way_now  = pend_q ? pend_way_q : preempt_way;

    // After reset the search starts at way 0 itself, so the first green is way 0.
    always_comb begin
        start_idx = fresh_q ? 0 : int'(active_way_q) + 1;
        sel_found = 1'b0;
        sel_way   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            idx = (start_idx + i) % NUM_WAYS;
            if (!sel_found && (!skip_en || demand[idx])) begin
                sel_found = 1'b1;
                sel_way   = 3'(idx);
            end
        end
    end

    always_comb begin
        phase_d      = phase_q;
        active_way_d = active_way_q;
        cnt_d        = cnt_q;
        fresh_d      = fresh_q;
        pend_d       = pend_q;
        pend_way_d   = pend_way_q;
        if (tick) begin
            unique case (phase_q)
                PH_ALLRED: begin
                    pend_d     = pend_now;
                    pend_way_d = pend_way_now;
                    if (fresh_q || cnt_q == A_LAST) begin
                        if (pend_now) begin
                            phase_d      = PH_PREEMPT;
                            active_way_d = pend_way_now;
                            cnt_d        = '0;
                            pend_d       = 1'b0;
                            fresh_d      = 1'b0;
                        end else if (sel_found) begin
                            phase_d      = PH_GREEN;
                            active_way_d = sel_way;
                            cnt_d        = '0;
                            fresh_d      = 1'b0;
                        end else begin
                            // No demand: park at terminal count and re-evaluate next tick.
                            cnt_d = A_LAST;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_GREEN: begin
                    if (preempt_valid) begin
                        cnt_d = '0;
                        if (preempt_way == active_way_q) begin
                            phase_d = PH_PREEMPT;
                        end else begin
                            phase_d    = PH_YELLOW;
                            pend_d     = 1'b1;
                            pend_way_d = preempt_way;
                        end
                    end else if (cnt_q == G_LAST) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_YELLOW: begin
                    pend_d     = pend_now;
                    pend_way_d = pend_way_now;
                    if (cnt_q == Y_LAST) begin
                        phase_d = PH_ALLRED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_PREEMPT: begin
                    if (!preempt_req) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = '0;
                    end
                end
                default: phase_d = PH_ALLRED;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_a_n) begin
        if (!rst_a_n) begin
            phase_q      <= PH_ALLRED;
            active_way_q <= '0;
            cnt_q        <= '0;
            fresh_q      <= 1'b1;
            pend_q       <= 1'b0;
            pend_way_q   <= '0;
        end else begin
            phase_q      <= phase_d;
            active_way_q <= active_way_d;
            cnt_q        <= cnt_d;
            fresh_q      <= fresh_d;
            pend_q       <= pend_d;
            pend_way_q   <= pend_way_d;
        end
    end

    always_comb begin
        lights = '0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (phase_q == PH_ALLRED || 3'(k) != active_way_q)
                lights[3*k +: 3] = LIGHT_RED;
            else if (phase_q == PH_YELLOW)
                lights[3*k +: 3] = LIGHT_YELLOW;
            else
                lights[3*k +: 3] = LIGHT_GREEN;
        end
    end

    assign active_way = active_way_q;
    assign phase      = phase_q;
    assign tick_out   = tick;

endmodule

// File: tb/tb_multi_way_traffic_ctrl.sv
// Bench for multi_way_traffic_ctrl: tick-level behavioural model compared every cycle,
// directed scenarios pinned by hand-computed values, then randomized stimulus.
module tb_multi_way_traffic_ctrl;

    localparam int NW = 4;
    localparam int TD = 2;
    localparam int GT = 3;
    localparam int YT = 2;
    localparam int AT = 1;

    logic          clk_in      = 1'b0;
    logic          rst_a_n     = 1'b1;
    logic          skip_en     = 1'b0;
    logic [NW-1:0] demand      = '0;
    logic          preempt_req = 1'b0;
    logic [2:0]    preempt_way = '0;
    logic [3*NW-1:0] lights;
    logic [2:0]    active_way;
    logic [1:0]    phase;
    logic          tick_out;

    multi_way_traffic_ctrl #(
        .NUM_WAYS(NW), .TICK_DIV(TD), .GREEN_TICKS(GT),
        .YELLOW_TICKS(YT), .ALLRED_TICKS(AT)
    ) dut (
        .clk_in      (clk_in),
        .rst_a_n     (rst_a_n),
        .skip_en     (skip_en),
        .demand      (demand),
        .preempt_req (preempt_req),
        .preempt_way (preempt_way),
        .lights      (lights),
        .active_way  (active_way),
        .phase       (phase),
        .tick_out    (tick_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0..3, way, ticks remaining in the current phase.
    int m_phase, m_way, m_rem, m_pway, m_edges, m_ticks;
    bit m_fresh, m_pend, m_tick;

    task automatic m_reset();
        m_phase = 0; m_way = 0; m_rem = AT; m_pway = 0;
        m_edges = 0; m_ticks = 0;
        m_fresh = 1; m_pend = 0; m_tick = 0;
    endtask

    task automatic m_step();
        bit pv;
        bit found;
        int start;
        pv = preempt_req && (int'(preempt_way) < NW);
        m_ticks++;
        case (m_phase)
            0: begin
                if (pv && !m_pend) begin m_pend = 1; m_pway = int'(preempt_way); end
                m_rem--;
                if (m_fresh || m_rem <= 0) begin
                    if (m_pend) begin
                        m_phase = 3; m_way = m_pway; m_pend = 0; m_fresh = 0;
                    end else begin
                        start = m_fresh ? 0 : m_way + 1;
                        found = 0;
                        for (int i = 0; i < NW; i++) begin
                            if (!found && (!skip_en || demand[(start + i) % NW])) begin
                                found = 1;
                                m_way = (start + i) % NW;
                            end
                        end
                        if (found) begin m_phase = 1; m_rem = GT; m_fresh = 0; end
                    end
                end
            end
            1: begin
                if (pv) begin
                    if (int'(preempt_way) == m_way) m_phase = 3;
                    else begin
                        m_phase = 2; m_rem = YT; m_pend = 1; m_pway = int'(preempt_way);
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin m_phase = 2; m_rem = YT; end
                end
            end
            2: begin
                if (pv && !m_pend) begin m_pend = 1; m_pway = int'(preempt_way); end
                m_rem--;
                if (m_rem == 0) begin m_phase = 0; m_rem = AT; end
            end
            default: begin
                if (!preempt_req) begin m_phase = 2; m_rem = YT; end
            end
        endcase
    endtask

    always @(posedge clk_in or negedge rst_a_n) begin
        if (!rst_a_n) m_reset();
        else begin
            if (m_tick) m_step();
            m_edges++;
            m_tick = (m_edges % TD) == 0;
        end
    end

    function automatic logic [3*NW-1:0] exp_lights();
        logic [3*NW-1:0] l;
        for (int w = 0; w < NW; w++) begin
            if (m_phase == 0 || w != m_way) l[3*w +: 3] = 3'b100;
            else if (m_phase == 2)          l[3*w +: 3] = 3'b010;
            else                            l[3*w +: 3] = 3'b001;
        end
        return l;
    endfunction

    bit check_en = 0;

    always @(negedge clk_in) begin
        if (check_en) begin
            int nonred;
            nonred = 0;
            for (int w = 0; w < NW; w++) if (lights[3*w +: 3] !== 3'b100) nonred++;
            check("cyc_phase", 32'(phase), 32'(m_phase));
            check("cyc_way", 32'(active_way), 32'(m_way));
            check("cyc_lights", 32'(lights), 32'(exp_lights()));
            check("cyc_tick", 32'(tick_out), 32'(m_tick));
            check("cyc_one_nonred", 32'(nonred <= 1), 32'd1);
        end
    end

    task automatic goto_tick(input int t);
        int guard;
        guard = 0;
        while (m_ticks < t && guard < 400) begin
            @(negedge clk_in);
            guard++;
        end
        if (m_ticks != t) begin
            tests++;
            fails++;
            $display("FAIL goto_tick: reached tick %0d, expected %0d", m_ticks, t);
        end
    endtask

    task automatic lit(input string name, input int t, input int ph, input int way);
        goto_tick(t);
        check({name, "_phase"}, 32'(phase), 32'(ph));
        check({name, "_way"}, 32'(active_way), 32'(way));
        check({name, "_model"}, 32'(m_phase), 32'(ph));
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_lights"}, 32'(lights), 32'h924);
        check({name, "_way"}, 32'(active_way), 32'd0);
        check({name, "_phase"}, 32'(phase), 32'd0);
        check({name, "_tick"}, 32'(tick_out), 32'd0);
    endtask

    // Reset driven between clock edges; outputs must change without a clock edge.
    task automatic pulse_reset(input string name);
        @(posedge clk_in);
        #2 rst_a_n = 1'b0;
        #1 check_reset_values(name);
        @(negedge clk_in);
        #1 rst_a_n = 1'b1;
    endtask

    initial begin
        #1 rst_a_n = 1'b0;
        #11 check_reset_values("por");
        check_en = 1;
        @(negedge clk_in);
        #1 rst_a_n = 1'b1;

        // Fixed rotation 0,1,2,3,0 with 3/2/1 tick dwells.
        lit("rot_g0", 1, 1, 0);
        lit("rot_y0", 4, 2, 0);
        lit("rot_r0", 6, 0, 0);
        lit("rot_g1", 7, 1, 1);
        check("rot_g1_lights", 32'(lights), 32'h90C);
        lit("rot_g2", 13, 1, 2);
        lit("rot_g3", 19, 1, 3);
        lit("rot_g0b", 25, 1, 0);
        lit("rot_y0b", 28, 2, 0);

        pulse_reset("mid_yellow_rst");
        lit("post_rst_g0", 1, 1, 0);

        // Out-of-range preemption target is ignored.
        pulse_reset("rst2");
        preempt_req = 1'b1;
        preempt_way = 3'd5;
        lit("bad_pre_g1", 7, 1, 1);
        lit("bad_pre_g2", 13, 1, 2);
        preempt_req = 1'b0;

        // Preemption to way 2 during green of way 0.
        pulse_reset("rst3");
        goto_tick(1);
        preempt_req = 1'b1;
        preempt_way = 3'd2;
        lit("pre_y0", 2, 2, 0);
        lit("pre_r", 4, 0, 0);
        lit("pre_hold", 5, 3, 2);
        check("pre_lights", 32'(lights), 32'h864);
        lit("pre_hold2", 8, 3, 2);
        preempt_req = 1'b0;
        lit("pre_y2", 9, 2, 2);
        lit("pre_r2", 11, 0, 2);
        lit("pre_g3", 12, 1, 3);

        // Demand skipping.
        pulse_reset("rst4");
        skip_en = 1'b1;
        demand  = 4'b1010;
        lit("skip_g1", 1, 1, 1);
        lit("skip_g3", 7, 1, 3);
        lit("skip_g1b", 13, 1, 1);
        demand = 4'b0000;
        lit("idle_a", 19, 0, 1);
        lit("idle_b", 24, 0, 1);
        check("idle_lights", 32'(lights), 32'h924);

        // Randomized traffic, demand and preemption.
        pulse_reset("rst5");
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_in);
            if ($urandom_range(0, 63) == 0) skip_en = ~skip_en;
            if ($urandom_range(0, 15) == 0) demand = NW'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                preempt_req = ~preempt_req;
                preempt_way = 3'($urandom_range(0, 7));
            end
        end

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
